// File: rtl/ofdm_tx_pkg.sv
// Shared OFDM transmitter definitions: sample packing, symbol-size defaults and the CP-insert state encoding.
package ofdm_tx_pkg;

  localparam int SAMPLE_W = 16;
  localparam int DATA_W   = 2 * SAMPLE_W;
  localparam int RE_LSB   = 0;
  localparam int IM_LSB   = SAMPLE_W;

  localparam int NFFT_DEF = 64;
  localparam int NCP_DEF  = 16;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_CP   = 2'd1,
    ST_SYM  = 2'd2
  } cp_state_e;

endpackage

// File: rtl/cp_insert_bank.sv
// One symbol buffer: NFFT x DATA_W register array, synchronous write, combinational read.
// Latency: a write at edge t is visible on rdat in the following cycle.
// Backpressure: none; the owner decides when we is asserted.
module cp_insert_bank
  import ofdm_tx_pkg::*;
#(
  parameter int NFFT = NFFT_DEF,
  parameter int AW   = $clog2(NFFT)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdat,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdat
);

  logic [DATA_W-1:0] mem [NFFT];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  assign rdat = mem[raddr];

endmodule

// File: rtl/cp_insert.sv
// Cyclic-prefix inserter: buffers an NFFT-sample symbol, replays its last NCP samples then the whole symbol.
// Latency: first prefix sample on DAT_O one cycle after the last input sample is written.
// Backpressure: ACK_O low while no bank is free, ACK_I low freezes the output; CP_INSERT_PINGPONG_EN adds a second bank.
module cp_insert
  import ofdm_tx_pkg::*;
#(
  parameter int NFFT = NFFT_DEF,
  parameter int NCP  = NCP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] DAT_I,
  input  logic              WE_I,
  input  logic              STB_I,
  input  logic              CYC_I,
  output logic              ACK_O,
  output logic [DATA_W-1:0] DAT_O,
  output logic              WE_O,
  output logic              STB_O,
  output logic              CYC_O,
  input  logic              ACK_I
);

  localparam int AW = $clog2(NFFT);
`ifdef CP_INSERT_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam logic [AW-1:0] CP_START  = AW'(NFFT - NCP);
  localparam logic [AW-1:0] LAST_SAMP = AW'(NFFT - 1);

  cp_state_e         state;
  logic [NB-1:0]     full;
  logic [NB-1:0]     set_full;
  logic [NB-1:0]     clr_full;
  logic              wr_bank;
  logic              rd_bank;
  logic              nxt_wr_bank;
  logic              nxt_rd_bank;
  logic              other_full;
  logic [AW-1:0]     wr_cnt;
  logic [AW-1:0]     rd_addr;
  logic [AW-1:0]     rd_addr_nxt;
  logic [DATA_W-1:0] rdat [NB];
  logic [DATA_W-1:0] rd_dat;
  logic              burst;
  logic              wr_acc;
  logic              sym_done;

  assign ACK_O  = ~rst & CYC_I & STB_I & WE_I & ~full[wr_bank];
  assign wr_acc = ACK_O;
  assign STB_O  = burst;
  assign WE_O   = burst;
  assign CYC_O  = burst;

  // The prefix always ends at NFFT-1, so a plain increment wraps into the body at address 0.
  assign rd_addr_nxt = burst ? rd_addr + 1'b1 : CP_START;
  assign rd_dat      = rdat[rd_bank];
  assign sym_done    = (state == ST_SYM) && ACK_I && (rd_addr == LAST_SAMP);

  assign set_full = (wr_acc && (wr_cnt == LAST_SAMP)) ? (NB'(1) << wr_bank) : '0;
  assign clr_full = sym_done ? (NB'(1) << rd_bank) : '0;

`ifdef CP_INSERT_PINGPONG_EN
  assign other_full  = full[~rd_bank];
  assign nxt_wr_bank = ~wr_bank;
  assign nxt_rd_bank = ~rd_bank;
`else
  assign other_full  = 1'b0;
  assign nxt_wr_bank = 1'b0;
  assign nxt_rd_bank = 1'b0;
`endif

  for (genvar b = 0; b < NB; b++) begin : g_bank
    cp_insert_bank #(.NFFT(NFFT), .AW(AW)) u_bank (
      .clk   (clk),
      .we    (wr_acc && (wr_bank == 1'(b))),
      .waddr (wr_cnt),
      .wdat  (DAT_I),
      .raddr (rd_addr_nxt),
      .rdat  (rdat[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FILL;
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_addr <= '0;
      DAT_O   <= '0;
      burst   <= 1'b0;
    end else begin
      full <= (full | set_full) & ~clr_full;

      if (wr_acc) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == LAST_SAMP) wr_bank <= nxt_wr_bank;
      end

      case (state)
        ST_SYM: begin
          if (ACK_I) begin
            if (rd_addr == LAST_SAMP) begin
              burst   <= 1'b0;
              rd_bank <= nxt_rd_bank;
              state   <= other_full ? ST_CP : ST_FILL;
            end else begin
              DAT_O   <= rd_dat;
              rd_addr <= rd_addr_nxt;
            end
          end
        end
        default: begin
          // CP entered with burst low is a back-to-back start: load the first prefix sample after the gap cycle.
          if (!burst) begin
            if (full[rd_bank]) begin
              state   <= ST_CP;
              burst   <= 1'b1;
              DAT_O   <= rd_dat;
              rd_addr <= rd_addr_nxt;
            end
          end else if (ACK_I) begin
            DAT_O   <= rd_dat;
            rd_addr <= rd_addr_nxt;
            if (rd_addr == LAST_SAMP) state <= ST_SYM;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/cp_insert.md
# cp_insert

Cyclic-prefix insertion stage of the OFDM transmitter. It sits directly downstream of the IFFT modulator and feeds the transmitter output port. It buffers each time-domain symbol of NFFT complex samples from the IFFT, then emits NCP prefix samples (the symbol's last NCP samples) followed by the full symbol. Both sides use the pipeline's CYC/STB/WE/ACK handshake.

## Interface
- NFFT, 64, samples per OFDM symbol; power of two, 16..256
- NCP, 16, cyclic-prefix length; 1..NFFT
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- DAT_I  in  32  input sample from IFFT, {Im[31:16], Re[15:0]}, two's complement
- WE_I  in  1  upstream write strobe
- STB_I  in  1  upstream data valid
- CYC_I  in  1  upstream cycle (symbol transfer in progress)
- ACK_O  out  1  input sample accepted this cycle
- DAT_O  out  32  output sample, same format as DAT_I
- WE_O  out  1  output write strobe
- STB_O  out  1  output data valid
- CYC_O  out  1  output cycle, high for the whole NCP+NFFT burst of one symbol
- ACK_I  in  1  downstream accepted DAT_O

## Operation
- Input transfer: when CYC_I & STB_I & WE_I & ACK_O are all high at a rising clk edge, the sample is written at address wr_cnt and wr_cnt increments.
- ACK_O is combinational: CYC_I & STB_I & WE_I & bank_free.
- When wr_cnt wraps from NFFT-1 to 0, the bank is marked full.
- A CYC_I drop mid-symbol pauses the fill; wr_cnt and the stored data are retained.
- States:
  - FILL: accept input; no output.
  - CP: emit addresses NFFT-NCP..NFFT-1.
  - SYM: emit addresses 0..NFFT-1.
  - FILL→CP when a bank is full. CP→SYM after NCP accepted outputs. SYM→FILL after NFFT accepted outputs, which also frees the bank. SYM→CP if another bank is already full (pingpong only).
- Output advance: on STB_O & ACK_I the next address is loaded into DAT_O. When ACK_I is low, DAT_O/STB_O/WE_O/CYC_O hold.
- WE_O = STB_O = CYC_O throughout a burst. All three drop in the cycle after the last SYM sample is accepted, and stay low for at least 1 cycle between bursts.
- Samples pass through unmodified: no scaling, no rounding.
- Reset (any time, including mid-burst):
  - outputs: ACK_O=0, STB_O=0, WE_O=0, CYC_O=0, DAT_O=0
  - counters: cleared
  - banks: marked free; partial symbols discarded.

## Timing
- Symbol memory is a register array with combinational read. DAT_O is registered.
- Latency: if the last input sample (index NFFT-1) is accepted at edge t, then after edge t+1 STB_O=1 and DAT_O=sample NFFT-NCP.
- Burst length: exactly NCP+NFFT accepted outputs per symbol. With ACK_I held high this takes NCP+NFFT cycles.
- Single-bank build: ACK_O=0 from the bank-full edge until the edge accepting the last SYM sample. Input throughput is therefore ≤ NFFT/(2NFFT+NCP+1).
- Simultaneous events: the bank being freed and a new input accepted on the same edge is legal. The write goes to address 0 of the freed bank.

## Configuration
- CP_INSERT_PINGPONG_EN
- Defined: two banks. Filling one bank proceeds while the other drains. ACK_O is low only when both banks are full. Burst order equals fill order. Bursts are back-to-back with a 1-cycle CYC_O gap.
- Undefined: one bank, with behaviour as in Timing.

## Structure
- Shared package ofdm_tx_pkg:
  - 16-bit Re/Im sample field widths and 32-bit packing positions
  - NFFT/NCP defaults
  - FSM state enum (FILL, CP, SYM)
- Sub-module cp_insert_bank: one NFFT×32 register array with write port and combinational read port. Instantiated once, or twice under CP_INSERT_PINGPONG_EN.

## Test plan
- Basic burst. Stimulus: NFFT=64, NCP=16, ACK_I=1, input k={Im=-k, Re=k}, k=0..63. Response: 80 outputs, Re=48..63 then 0..63. CYC_O drops after the 80th.
- Downstream stall. Stimulus: ACK_I low for 7 cycles at output 10 and again at output 40. Response: DAT_O/STB_O frozen during each stall; sequence identical to basic burst; no duplicates or drops.
- Upstream gap. Stimulus: CYC_I/STB_I low for 5 cycles after input 20. Response: fill resumes at index 21; output sequence unchanged.
- Back-pressure. Stimulus: second symbol (Re=100+k) offered during drain.
  - Single bank: ACK_O=0 until the first burst ends.
  - Pingpong: accepted at once; second burst starts after a 1-cycle gap, Re=148..163, 100..163.
- Reset mid-burst. Stimulus: rst at output 30.
  - Next cycle: all outputs 0.
  - Then a fresh symbol gives a correct 80-sample burst with no stale data.
- Edge parameters. Stimulus: NCP=NFFT=16 with ramp input. Response: 32 outputs, Re=0..15 twice.
